// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and the memory.
// The slave modport is the arbiter's view; the master modport is the requester/memory side.
interface dmem_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              m0_req;
  logic              m0_we;
  logic [31:0]       m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt;
  logic              m0_rvalid;
  logic [DATA_W-1:0] m0_rdata;
  logic              m0_err;

  logic              m1_req;
  logic              m1_we;
  logic [31:0]       m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt;
  logic              m1_rvalid;
  logic [DATA_W-1:0] m1_rdata;
  logic              m1_err;

  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata, m0_err,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata, m1_err,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-ported data memory: IDLE -> ACCESS -> RESP per access.
// Define DMEM_ARB_RR_EN for round-robin; otherwise port 0 has priority with a starvation override.
module dmem_arbiter #(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  dmem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              gnt_q, gnt_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              win1;
  logic              in_range;
  logic              in_access;
  logic              in_resp;
  logic              arb_fire;

  function automatic logic addr_in_range(input logic [31:0] a);
    return (a >> ADDR_W) == 32'd0;
  endfunction

  assign in_range  = addr_in_range(addr_q);
  assign in_access = (state_q == ACCESS);
  assign in_resp   = (state_q == RESP);
  assign arb_fire  = (state_q == IDLE) && (bus.m0_req || bus.m1_req);

`ifdef DMEM_ARB_RR_EN
  logic last_q, last_d;

  // On contention the port that lost the previous arbitration wins.
  always_comb win1 = bus.m1_req & (~bus.m0_req | ~last_q);

  always_comb begin
    last_d = last_q;
    if (arb_fire) last_d = win1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_q <= 1'b1;
    else       last_q <= last_d;
  end
`else
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  logic [3:0] starve_q, starve_d;

  always_comb win1 = bus.m1_req & (~bus.m0_req | (starve_q == STARVE_LIM));

  // Counts port-0 wins over a waiting port 1; any IDLE cycle without m1_req clears it.
  always_comb begin
    starve_d = starve_q;
    if (state_q == IDLE) begin
      if (!bus.m1_req || win1)
        starve_d = '0;
      else if (bus.m0_req && (starve_q != STARVE_LIM))
        starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) starve_q <= '0;
    else       starve_q <= starve_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    gnt_d   = 1'b0;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (arb_fire) begin
          owner_d = win1;
          we_d    = win1 ? bus.m1_we    : bus.m0_we;
          addr_d  = win1 ? bus.m1_addr  : bus.m0_addr;
          wdata_d = win1 ? bus.m1_wdata : bus.m0_wdata;
          gnt_d   = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // Memory read is combinational, so data is captured on the edge closing ACCESS.
        rdata_d = (~we_q & in_range) ? bus.mem_rdata : '0;
        err_d   = ~in_range;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.mem_read  = in_access & ~we_q & in_range;
  assign bus.mem_write = in_access & we_q & in_range;
  assign bus.mem_addr  = in_access ? addr_q  : '0;
  assign bus.mem_wdata = in_access ? wdata_q : '0;

  assign bus.m0_gnt    = gnt_q & ~owner_q;
  assign bus.m1_gnt    = gnt_q & owner_q;
  assign bus.m0_rvalid = in_resp & ~owner_q;
  assign bus.m1_rvalid = in_resp & owner_q;
  assign bus.m0_rdata  = (in_resp & ~owner_q) ? rdata_q : '0;
  assign bus.m1_rdata  = (in_resp & owner_q)  ? rdata_q : '0;
  assign bus.m0_err    = in_resp & ~owner_q & err_q;
  assign bus.m1_err    = in_resp & owner_q & err_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: vector table, corner sequences and a randomized run
// against a transaction-level model (grant order, response data, error flag).
module tb_dmem_arbiter;
  localparam int ADDR_W     = 6;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  logic reset;

  dmem_arbiter_if #(.DATA_W(DATA_W)) bus();

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [64];
  assign bus.mem_rdata = mem[bus.mem_addr[5:0]];
  always @(posedge clk) if (bus.mem_write) mem[bus.mem_addr[5:0]] <= bus.mem_wdata;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int p, input bit req, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata);
    if (p == 0) begin
      bus.m0_req = req; bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wdata;
    end else begin
      bus.m1_req = req; bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wdata;
    end
  endtask

  function automatic logic gnt_of(input int p);
    return (p == 0) ? bus.m0_gnt : bus.m1_gnt;
  endfunction
  function automatic logic rv_of(input int p);
    return (p == 0) ? bus.m0_rvalid : bus.m1_rvalid;
  endfunction
  function automatic logic [31:0] rd_of(input int p);
    return (p == 0) ? bus.m0_rdata : bus.m1_rdata;
  endfunction
  function automatic logic err_of(input int p);
    return (p == 0) ? bus.m0_err : bus.m1_err;
  endfunction
  function automatic logic any_out();
    return |{bus.m0_gnt, bus.m0_rvalid, bus.m0_rdata, bus.m0_err,
             bus.m1_gnt, bus.m1_rvalid, bus.m1_rdata, bus.m1_err,
             bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata};
  endfunction

  // Called from an IDLE cycle, #1 after the edge; returns in IDLE, #1 after an edge.
  task automatic do_txn(input int p, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd, input bit exp_err);
    drive(p, 1'b1, we, addr, wdata);
    @(posedge clk); #1;
    chk("gnt", 64'(gnt_of(p)), 64'(1));
    chk("gnt_other", 64'(gnt_of(1 - p)), 64'(0));
    chk("mem_write", 64'(bus.mem_write), 64'(we && !exp_err));
    chk("mem_read", 64'(bus.mem_read), 64'(!we && !exp_err));
    chk("mem_addr", 64'(bus.mem_addr), 64'(addr));
    chk("mem_wdata", 64'(bus.mem_wdata), 64'(wdata));
    drive(p, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk); #1;
    chk("rvalid", 64'(rv_of(p)), 64'(1));
    chk("rvalid_other", 64'(rv_of(1 - p)), 64'(0));
    chk("rdata", 64'(rd_of(p)), 64'(exp_rd));
    chk("err", 64'(err_of(p)), 64'(exp_err));
    chk("rdata_other", 64'(rd_of(1 - p)), 64'(0));
    chk("mem_idle_resp", 64'({bus.mem_read, bus.mem_write}), 64'(0));
    @(posedge clk); #1;
    chk("rvalid_done", 64'({bus.m0_rvalid, bus.m1_rvalid}), 64'(0));
  endtask

  typedef struct {
    int          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t vt[10];
  int   exp_order[10];
  int   order[$];

  // randomized-phase state
  logic [31:0] ref_mem [64];
  bit          p_act [2];
  bit          p_rel [2];
  bit          p_we  [2];
  logic [31:0] p_addr [2];
  logic [31:0] p_wdata [2];

  initial begin
    int k;
    bit got;
    int busy, rv_port, wait_wins, last_w, w;
    bit rv_pend, rv_now, eg0, eg1, e_err;
    logic [31:0] e_rd;

    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    chk("reset_outputs", 64'(any_out()), 64'(0));
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_outputs", 64'(any_out()), 64'(0));

    vt[0] = '{0, 1'b1, 32'd20, 32'd69, 32'd0, 1'b0};
    vt[1] = '{0, 1'b0, 32'd20, 32'd0, 32'd69, 1'b0};
    vt[2] = '{1, 1'b1, 32'd10, 32'd77, 32'd0, 1'b0};
    vt[3] = '{1, 1'b0, 32'd10, 32'd0, 32'd77, 1'b0};
    vt[4] = '{0, 1'b0, 32'd64, 32'd0, 32'd0, 1'b1};
    vt[5] = '{0, 1'b1, 32'd64, 32'h55, 32'd0, 1'b1};
    vt[6] = '{1, 1'b0, 32'hFFFF_FFC0, 32'd0, 32'd0, 1'b1};
    vt[7] = '{0, 1'b1, 32'd63, 32'hA5A5_5A5A, 32'd0, 1'b0};
    vt[8] = '{1, 1'b0, 32'd63, 32'd0, 32'hA5A5_5A5A, 1'b0};
    vt[9] = '{1, 1'b0, 32'd20, 32'd0, 32'd69, 1'b0};
    for (int i = 0; i < 10; i++)
      do_txn(vt[i].port, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].exp_rd, vt[i].exp_err);

    // contention with both ports requesting every cycle
`ifdef DMEM_ARB_RR_EN
    exp_order = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
`endif
    reset = 1'b1; #2; reset = 1'b0;
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 32'd1, 32'd0);
    drive(1, 1'b1, 1'b0, 32'd2, 32'd0);
    k = 0;
    while (order.size() < 10 && k < 60) begin
      @(posedge clk); #1; k++;
      if (bus.m0_gnt) order.push_back(0);
      if (bus.m1_gnt) order.push_back(1);
    end
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("contention_grants", 64'(order.size()), 64'(10));
    for (int i = 0; i < 10 && i < order.size(); i++)
      chk("grant_order", 64'(order[i]), 64'(exp_order[i]));
    repeat (3) @(posedge clk);
    #1;

    // reset during ACCESS of an m1 write
    drive(1, 1'b1, 1'b1, 32'd19, 32'h1234_5678);
    @(posedge clk); #1;
    chk("rst_seq_gnt", 64'(bus.m1_gnt), 64'(1));
    reset = 1'b1; #1;
    chk("rst_async_zero", 64'(any_out()), 64'(0));
    @(posedge clk); #1;
    chk("rst_edge_zero", 64'(any_out()), 64'(0));
    reset = 1'b0;
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk); #1;
    chk("rst_no_rvalid", 64'(bus.m1_rvalid), 64'(0));
    @(posedge clk); #1;
    chk("rst_no_rvalid2", 64'(bus.m1_rvalid), 64'(0));
    do_txn(1, 1'b1, 32'd19, 32'h1234_5678, 32'd0, 1'b0);
    do_txn(1, 1'b0, 32'd19, 32'd0, 32'h1234_5678, 1'b0);

    // m0 write immediately followed by m1 read of the same word
    drive(0, 1'b1, 1'b1, 32'd5, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    chk("raw_m0_gnt", 64'(bus.m0_gnt), 64'(1));
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b1, 1'b0, 32'd5, 32'd0);
    k = 0; got = 1'b0;
    while (k < 10 && !got) begin
      @(posedge clk); #1; k++;
      if (bus.m1_gnt) got = 1'b1;
    end
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("raw_gnt_gap", 64'(k), 64'(3));
    @(posedge clk); #1;
    chk("raw_rvalid", 64'(bus.m1_rvalid), 64'(1));
    chk("raw_rdata", 64'(bus.m1_rdata), 64'(32'hDEAD_BEEF));
    chk("raw_m0_quiet", 64'({bus.m0_gnt, bus.m0_rvalid, bus.m0_err}), 64'(0));
    @(posedge clk); #1;

    // randomized traffic against a transaction-level model
    reset = 1'b1; #2; reset = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = mem[i];
    for (int p = 0; p < 2; p++) begin
      p_act[p] = 1'b0; p_rel[p] = 1'b0; p_we[p] = 1'b0; p_addr[p] = '0; p_wdata[p] = '0;
    end
    busy = 0; rv_pend = 1'b0; rv_port = 0; wait_wins = 0; last_w = 1;
    e_rd = '0; e_err = 1'b0;
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      rv_now = rv_pend; rv_pend = 1'b0;
      eg0 = 1'b0; eg1 = 1'b0;
      if (busy == 0) begin
        if (p_act[0] || p_act[1]) begin
`ifdef DMEM_ARB_RR_EN
          w = (p_act[0] && p_act[1]) ? ((last_w == 0) ? 1 : 0) : (p_act[1] ? 1 : 0);
          last_w = w;
`else
          w = (p_act[0] && p_act[1]) ? ((wait_wins == STARVE_MAX) ? 1 : 0) : (p_act[1] ? 1 : 0);
          if (w == 1) wait_wins = 0;
          else if (p_act[1] && wait_wins < STARVE_MAX) wait_wins++;
`endif
          if (w == 0) eg0 = 1'b1; else eg1 = 1'b1;
          e_err = (p_addr[w] >= 32'd64);
          e_rd  = (!p_we[w] && !e_err) ? ref_mem[p_addr[w][5:0]] : 32'd0;
          if (p_we[w] && !e_err) ref_mem[p_addr[w][5:0]] = p_wdata[w];
          rv_pend = 1'b1; rv_port = w; busy = 2;
        end
        if (!p_act[1]) wait_wins = 0;
      end else begin
        busy--;
      end
      chk("rnd_gnt0", 64'(bus.m0_gnt), 64'(eg0));
      chk("rnd_gnt1", 64'(bus.m1_gnt), 64'(eg1));
      if (rv_now) begin
        chk("rnd_rvalid", 64'(rv_of(rv_port)), 64'(1));
        chk("rnd_rvalid_other", 64'(rv_of(1 - rv_port)), 64'(0));
        chk("rnd_rdata", 64'(rd_of(rv_port)), 64'(e_rd));
        chk("rnd_err", 64'(err_of(rv_port)), 64'(e_err));
      end else begin
        chk("rnd_no_rvalid", 64'({bus.m0_rvalid, bus.m1_rvalid}), 64'(0));
      end
      for (int p = 0; p < 2; p++) begin
        if (p_rel[p]) begin p_act[p] = 1'b0; p_rel[p] = 1'b0; end
        if ((p == 0 && eg0) || (p == 1 && eg1)) p_rel[p] = 1'b1;
        if (!p_act[p] && !p_rel[p] && $urandom_range(0, 1) == 1) begin
          p_act[p]   = 1'b1;
          p_we[p]    = 1'($urandom_range(0, 1));
          p_addr[p]  = ($urandom_range(0, 15) == 0) ? 32'($urandom) : 32'($urandom_range(0, 70));
          p_wdata[p] = 32'($urandom);
        end
        drive(p, p_act[p], p_we[p], p_addr[p], p_wdata[p]);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-ported 64-word data memory between two requesters: port 0 (CPU load/store unit) and port 1 (debug/program-loader master).
- Sits between the requesters and the data memory's MemRead/MemWrite/Mem_Addr/wr_data/rd_data interface.
- Serialises accesses through a 3-state FSM, with fixed priority to port 0 and starvation protection for port 1.

Parameters:
- ADDR_W, 6, word-address width of the memory (depth = 2**ADDR_W).
- DATA_W, 32, data width.
- STARVE_MAX, 4, number of consecutive port-0 wins while port 1 waits before port 1 is forced a grant (1..15).

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- m0_req  input  1  port 0 request; held high with stable fields until m0_gnt.
- m0_we  input  1  port 0: 1 = write, 0 = read.
- m0_addr  input  32  port 0 word address.
- m0_wdata  input  DATA_W  port 0 write data.
- m0_gnt  output  1  port 0 request accepted (1-cycle pulse).
- m0_rvalid  output  1  port 0 response valid (1-cycle pulse; for writes it is the ack).
- m0_rdata  output  DATA_W  port 0 read data, valid with m0_rvalid.
- m0_err  output  1  port 0 address out of range, valid with m0_rvalid.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata, m1_err: same directions, widths and meanings for port 1.
- mem_read  output  1  drives the memory MemRead.
- mem_write  output  1  drives the memory MemWrite.
- mem_addr  output  32  drives the memory Mem_Addr.
- mem_wdata  output  DATA_W  drives the memory wr_data.
- mem_rdata  input  DATA_W  memory rd_data (combinational read).

Behaviour:
- Reset value of all outputs is 0. Internal state on reset: FSM = IDLE, owner = 0, starve_cnt = 0, latched request and rdata registers = 0.
- FSM states: IDLE -> ACCESS -> RESP -> IDLE. Fixed 3-cycle occupancy per access. Maximum throughput is one access per 3 cycles.
- IDLE, arbitration:
  - Only one req high: that port wins.
  - Both high: port 1 wins if starve_cnt == STARVE_MAX, otherwise port 0.
  - Winner's we/addr/wdata are latched and owner is recorded.
  - Next state is ACCESS.
  - If neither req is high, stay in IDLE.
- mX_gnt:
  - Registered; high exactly during the first ACCESS cycle for the owner.
  - The requester may drop or change req from the cycle after gnt.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) when port 0 wins while m1_req is high.
  - Clears when port 1 wins or when m1_req is low at arbitration.
- ACCESS:
  - mem_addr = latched addr; mem_wdata = latched wdata.
  - mem_write = latched we & in_range; mem_read = ~latched we & in_range.
  - Read data is captured from mem_rdata at the end of the cycle (0 for writes or out-of-range accesses).
  - Next state is RESP.
  - The memory write therefore commits on the clk edge ending ACCESS.
- In-range rule: in_range = (addr[31:ADDR_W] == 0). When out of range:
  - No memory strobe is issued.
  - rdata = 0 and mX_err = 1 in RESP.
- RESP:
  - Owner's mX_rvalid = 1, with mX_rdata and mX_err from registers.
  - All mem_* outputs are 0.
  - Next state is IDLE.
  - A req arriving during RESP is arbitrated in the following IDLE cycle.
- mem_* outputs are 0 in IDLE and RESP. The non-owner's gnt/rvalid/err stay 0 at all times.
- Read-after-write from either port returns the newly written value: the write commits before the next ACCESS.
- Reset asserted mid-transaction: the FSM returns to IDLE immediately and the transaction is dropped.
  - No rvalid is issued.
  - A write whose ACCESS edge coincides with reset is not guaranteed to commit.
  - The requester must re-issue.

Optional Feature:
- Macro: DMEM_ARB_RR_EN.
- Defined: round-robin arbitration. When both ports request, the port that did not win the previous arbitration wins. Last-winner resets to 1, so port 0 wins the first contention. starve_cnt and STARVE_MAX are unused.
- Undefined: fixed priority to port 0 with STARVE_MAX starvation override, as described above.

Test Plan:
- Reset, then m0 write addr 20 data 69 -> m0_gnt in cycle 1 after req. mem_write=1, mem_addr=20 in that cycle. m0_rvalid=1 in cycle 2, m0_err=0. A subsequent m0 read of addr 20 returns m0_rdata=69.
- m1 read addr 10, pre-written with 77 -> m1_gnt, then m1_rvalid with m1_rdata=77. m0 outputs stay 0 throughout.
- m0 and m1 both requesting continuously, STARVE_MAX=4 -> grant order 0,0,0,0,1,0,0,0,0,1. With DMEM_ARB_RR_EN defined -> 0,1,0,1.
- m0 read addr 64 (out of range) -> mem_read and mem_write stay 0. m0_rvalid=1, m0_err=1, m0_rdata=0.
- Reset pulsed during ACCESS of an m1 write to addr 19 -> all outputs 0 on the next edge, FSM in IDLE, no m1_rvalid. A re-issued request completes normally.
- m0 write addr 5 data 0xDEADBEEF, immediately followed by m1 read addr 5 -> m1_rdata=0xDEADBEEF. m1_gnt occurs 3 cycles after m0_gnt.
